// File: rtl/swap_pkg.sv
// Shared types and widths for the 64-bit swap datapath.
package swap_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_AW = 5;

  // Writeback sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } state_t;

  // One aligned operand pair with both destination registers
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
  } pair_t;

endpackage

// File: rtl/swap_pair_fifo.sv
// Synchronous pair FIFO with push/pop and an occupancy count.
module swap_pair_fifo
  import swap_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  pair_t                        wdata,
  output pair_t                        rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  pair_t           mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage write at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/swap_wb_64.sv
// Writeback of swapped operand pairs: ra <- b, then rb <- a, through one write port.
// AW must not exceed swap_pkg::REG_AW (addresses are stored in the pair record).
module swap_wb_64
  import swap_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_a,
  input  logic [DATA_W-1:0]           in_b,
  input  logic [AW-1:0]               in_ra,
  input  logic [AW-1:0]               in_rb,
  output logic                        wr_en,
  output logic [AW-1:0]               wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  state_t state;
  pair_t  in_pair;
  pair_t  head;
  logic   full;
  logic   empty;
  logic   pop;

  assign in_pair.a  = in_a;
  assign in_pair.b  = in_b;
  assign in_pair.ra = REG_AW'(in_ra);
  assign in_pair.rb = REG_AW'(in_rb);

  // Head is retired on the edge that leaves WR1
  assign pop      = (state == WR1);
  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;

  swap_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_pair),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Sequencer and registered write port; zero address and duplicate second write are masked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (state)
        WR1: begin
          wr_addr <= AW'(head.rb);
          wr_data <= head.a;
          wr_en   <= (head.rb != '0) && (head.rb != head.ra);
          state   <= WR2;
        end
        default: begin
          if (!empty) begin
            wr_addr <= AW'(head.ra);
            wr_data <= head.b;
            wr_en   <= (head.ra != '0);
            state   <= WR1;
          end else begin
            wr_en   <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
